// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and constants for the ring-oscillator PUF challenge sequencer.
package puf_challenge_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int DEF_SEL_W         = 4;
   localparam int DEF_CNT_W         = 8;
   localparam int DEF_RESP_BITS     = 8;
   localparam int DEF_WINDOW_CYCLES = 1024;
   localparam int DEF_SETTLE_CYCLES = 4;

   // Enough bits to count ties from 0 up to and including every pair of a run.
   function automatic int tie_width(input int bits);
      return $clog2(bits + 1);
   endfunction

   // The window timer must hold the larger of the two preload values (cycles - 1).
   function automatic int timer_width(input int window, input int settle);
      int longest;
      longest = (window > settle) ? window : settle;
      return (longest > 1) ? $clog2(longest) : 1;
   endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter whose zero flag marks the last cycle of an oscillator
// window or of the settling period that follows it.
module puf_window_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Steps through RESP_BITS oscillator pairs derived from a base challenge, gates
// each pair for a fixed window and assembles one comparison bit per pair.
module puf_challenge_sequencer
   import puf_challenge_sequencer_pkg::*;
#(
   parameter int SEL_W         = DEF_SEL_W,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int RESP_BITS     = DEF_RESP_BITS,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [SEL_W-1:0]                  challenge,
   input  logic [CNT_W-1:0]                  cnt_a,
   input  logic [CNT_W-1:0]                  cnt_b,
   output logic [SEL_W-1:0]                  sel_a,
   output logic [SEL_W-1:0]                  sel_b,
   output logic                              osc_en,
   output logic                              cnt_clr,
   output logic                              busy,
   output logic                              resp_valid,
   output logic [RESP_BITS-1:0]              response,
   output logic [tie_width(RESP_BITS)-1:0]   tie_cnt
);

   localparam int TIE_W = tie_width(RESP_BITS);
   localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int TMR_W = timer_width(WINDOW_CYCLES, SETTLE_CYCLES);

   state_t             state;
   logic [SEL_W-1:0]   base;
   logic [IDX_W-1:0]   idx;
   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_load_val;
   logic               tmr_dec;
   logic               tmr_zero;

   // Pair n uses oscillators base+2n and base+2n+1, wrapping modulo 2^SEL_W.
   function automatic logic [SEL_W-1:0] pair_sel(input logic [SEL_W-1:0] b,
                                                 input logic [IDX_W-1:0] n);
      logic [IDX_W:0] twice;
      twice = {n, 1'b0};
      return b + SEL_W'(twice);
   endfunction

   puf_window_timer #(
      .WIDTH(TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // CLEAR preloads the window; the last RUN cycle reloads for the settle period.
   always_comb begin
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      case (state)
         CLEAR: begin
            tmr_load     = 1'b1;
            tmr_load_val = TMR_W'(WINDOW_CYCLES - 1);
         end
         RUN: begin
            if (tmr_zero) begin
               tmr_load     = 1'b1;
               tmr_load_val = TMR_W'(SETTLE_CYCLES - 1);
            end else begin
               tmr_dec = 1'b1;
            end
         end
         SETTLE:  tmr_dec = !tmr_zero;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= IDLE;
         base       <= '0;
         idx        <= '0;
         sel_a      <= '0;
         sel_b      <= '0;
         osc_en     <= 1'b0;
         cnt_clr    <= 1'b0;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         response   <= '0;
         tie_cnt    <= '0;
      end else begin
         cnt_clr    <= 1'b0;
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base     <= challenge;
                  idx      <= '0;
                  response <= '0;
                  tie_cnt  <= '0;
                  sel_a    <= pair_sel(challenge, '0);
                  sel_b    <= pair_sel(challenge, '0) + SEL_W'(1);
                  cnt_clr  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               osc_en <= 1'b1;
               state  <= RUN;
            end
            RUN: begin
               if (tmr_zero) begin
                  osc_en <= 1'b0;
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (tmr_zero) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               // Counters are frozen here, so the raw values compare safely.
               response[idx] <= (cnt_a > cnt_b);
               if (cnt_a == cnt_b) begin
                  tie_cnt <= tie_cnt + TIE_W'(1);
               end
               if (idx == IDX_W'(RESP_BITS - 1)) begin
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx     <= idx + IDX_W'(1);
                  sel_a   <= pair_sel(base, idx + IDX_W'(1));
                  sel_b   <= pair_sel(base, idx + IDX_W'(1)) + SEL_W'(1);
                  cnt_clr <= 1'b1;
                  state   <= CLEAR;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               osc_en <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized bench for puf_challenge_sequencer with a table-driven oscillator fabric
// and a pair-by-pair reference model of the expected response.
module tb_puf_challenge_sequencer;

   localparam int SW  = 4;
   localparam int CW  = 8;
   localparam int RB  = 8;
   localparam int WIN = 16;
   localparam int SET = 4;
   localparam int LAT = RB * (WIN + SET + 2) + 1;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [SW-1:0] challenge;
   logic [CW-1:0] cnt_a;
   logic [CW-1:0] cnt_b;
   logic [SW-1:0] sel_a;
   logic [SW-1:0] sel_b;
   logic          osc_en;
   logic          cnt_clr;
   logic          busy;
   logic          resp_valid;
   logic [RB-1:0] response;
   logic [3:0]    tie_cnt;

   logic [CW-1:0] fab_a [16];
   logic [CW-1:0] fab_b [16];

   int n_checks;
   int n_fails;

   puf_challenge_sequencer #(
      .SEL_W         (SW),
      .CNT_W         (CW),
      .RESP_BITS     (RB),
      .WINDOW_CYCLES (WIN),
      .SETTLE_CYCLES (SET)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .challenge  (challenge),
      .cnt_a      (cnt_a),
      .cnt_b      (cnt_b),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .osc_en     (osc_en),
      .cnt_clr    (cnt_clr),
      .busy       (busy),
      .resp_valid (resp_valid),
      .response   (response),
      .tie_cnt    (tie_cnt)
   );

   // Each oscillator group reports the count of whichever oscillator it selects.
   assign cnt_a = fab_a[sel_a];
   assign cnt_b = fab_b[sel_b];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic fillFabric(input int mode);
      for (int j = 0; j < 16; j++) begin
         case (mode)
            0: begin fab_a[j] = 8'd200; fab_b[j] = 8'd100; end
            1: begin fab_a[j] = 8'd5;   fab_b[j] = 8'd5;   end
            2: begin fab_a[j] = 8'd100; fab_b[j] = ((j >> 1) & 1) ? 8'd50 : 8'd150; end
            3: begin fab_a[j] = 8'($urandom_range(0, 3)); fab_b[j] = 8'($urandom_range(0, 3)); end
            default: begin fab_a[j] = 8'($urandom); fab_b[j] = 8'($urandom); end
         endcase
      end
   endtask

   // One full run; glitch_at injects a stray start, reset_at aborts via reset.
   task automatic applyStimulus(input int chal, input int glitch_at, input int reset_at);
      int cyc, pair, run_len, exp_resp, exp_ties, a, b;
      bit done, aborted;
      exp_resp = 0;
      exp_ties = 0;
      for (int i = 0; i < RB; i++) begin
         a = int'(fab_a[(chal + 2 * i) % 16]);
         b = int'(fab_b[(chal + 2 * i + 1) % 16]);
         if (a > b)  exp_resp = exp_resp | (1 << i);
         if (a == b) exp_ties++;
      end
      @(negedge clk);
      challenge = SW'(chal);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      challenge = SW'($urandom);
      cyc = 1; pair = 0; run_len = 0; done = 1'b0; aborted = 1'b0;
      while (!done && !aborted && cyc <= 3 * LAT) begin
         if (cyc == reset_at) begin
            checkOutput("pre_reset_osc_en", int'(osc_en), 1);
            rst_n = 1'b1;
            #1;
            checkOutput("abort_osc_en", int'(osc_en), 0);
            checkOutput("abort_busy", int'(busy), 0);
            checkOutput("abort_response", int'(response), 0);
            checkOutput("abort_tie_cnt", int'(tie_cnt), 0);
            @(negedge clk);
            rst_n = 1'b0;
            a = 0;
            repeat (20) begin
               @(negedge clk);
               if (resp_valid || busy) a++;
            end
            checkOutput("abort_quiet", a, 0);
            aborted = 1'b1;
         end else begin
            if (cnt_clr) begin
               checkOutput("sel_a", int'(sel_a), (chal + 2 * pair) % 16);
               checkOutput("sel_b", int'(sel_b), (chal + 2 * pair + 1) % 16);
               pair++;
            end
            if (osc_en) begin
               run_len++;
            end else if (run_len != 0) begin
               checkOutput("osc_window", run_len, WIN);
               run_len = 0;
            end
            if (resp_valid) begin
               checkOutput("latency", cyc, LAT);
               checkOutput("response", int'(response), exp_resp);
               checkOutput("tie_cnt", int'(tie_cnt), exp_ties);
               checkOutput("done_busy", int'(busy), 1);
               done = 1'b1;
            end else begin
               @(negedge clk);
               cyc++;
               start = (cyc == glitch_at);
               if (start) challenge = SW'(chal + 5);
            end
         end
      end
      start = 1'b0;
      if (!aborted) begin
         if (!done) checkOutput("resp_timeout", 0, 1);
         checkOutput("pair_count", pair, RB);
         @(negedge clk);
         checkOutput("valid_pulse", int'(resp_valid), 0);
         repeat (3) @(negedge clk);
         checkOutput("idle_busy", int'(busy), 0);
         checkOutput("idle_osc_en", int'(osc_en), 0);
         checkOutput("held_response", int'(response), exp_resp);
         checkOutput("held_sel_a", int'(sel_a), (chal + 2 * (RB - 1)) % 16);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      rst_n     = 1'b1;
      start     = 1'b0;
      challenge = '0;
      fillFabric(0);
      repeat (3) @(negedge clk);
      checkOutput("rst_sel_a", int'(sel_a), 0);
      checkOutput("rst_sel_b", int'(sel_b), 0);
      checkOutput("rst_osc_en", int'(osc_en), 0);
      checkOutput("rst_cnt_clr", int'(cnt_clr), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_resp_valid", int'(resp_valid), 0);
      checkOutput("rst_response", int'(response), 0);
      checkOutput("rst_tie_cnt", int'(tie_cnt), 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      fillFabric(0); applyStimulus(0, -1, -1);
      fillFabric(1); applyStimulus(0, -1, -1);
      fillFabric(4); applyStimulus(14, -1, -1);
      fillFabric(2); applyStimulus(0, -1, -1);
      fillFabric(4); applyStimulus(3, 50, -1);
      fillFabric(0); applyStimulus(6, -1, 90);
      fillFabric(0); applyStimulus(6, -1, -1);
      fillFabric(4); applyStimulus(15, -1, -1);
      for (int r = 0; r < 6; r++) begin
         fillFabric((r % 2 == 0) ? 3 : 4);
         applyStimulus(int'($urandom_range(0, 15)), -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Digital initiator for the ring-oscillator PUF array. It issues challenge pairs as oscillator select codes and gates the oscillators for a fixed system-clock window. After the counters have settled, it samples the two 8-bit oscillator counts and compares them. One response bit is produced per pair, and RESP_BITS bits are assembled into a response word with a valid pulse. It sits between the host/test logic and the oscillator/mux/counter fabric, and replaces the free-running comparator output with a controlled, repeatable measurement.

Parameters:
SEL_W, 4, width of oscillator select code (16 oscillators)
CNT_W, 8, width of oscillator counter values
RESP_BITS, 8, response bits per challenge run
WINDOW_CYCLES, 1024, clk cycles oscillators stay enabled per pair (>=1)
SETTLE_CYCLES, 4, clk cycles waited after disabling before sampling counts (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high
start  in  1  begin run; sampled only in IDLE
challenge  in  SEL_W  base challenge, latched on accepted start
cnt_a  in  CNT_W  count of oscillator selected by sel_a
cnt_b  in  CNT_W  count of oscillator selected by sel_b
sel_a  out  SEL_W  select code, oscillator group A
sel_b  out  SEL_W  select code, oscillator group B
osc_en  out  1  oscillator enable
cnt_clr  out  1  counter clear, high for 1 cycle per pair
busy  out  1  high whenever state != IDLE
resp_valid  out  1  1-cycle pulse when response is complete
response  out  RESP_BITS  assembled response word, held until the next accepted start
tie_cnt  out  $clog2(RESP_BITS+1)  number of pairs with cnt_a == cnt_b in the last run

Behaviour:
- Reset (rst_n=1): state IDLE; pair index 0; sel_a=0, sel_b=0, osc_en=0, cnt_clr=0, busy=0, resp_valid=0, response=0, tie_cnt=0.
- All outputs are registered.
- States and transitions:
  - IDLE -> CLEAR when start=1. On this transition, challenge is latched, pair index i=0, response and tie_cnt are cleared.
  - CLEAR (1 cycle): cnt_clr=1; sel_a=(base+2i) mod 2^SEL_W; sel_b=(base+2i+1) mod 2^SEL_W. Next state RUN.
  - RUN (exactly WINDOW_CYCLES cycles): osc_en=1; selects stable. Next state SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): osc_en=0. Counter values become static, so no synchronizer is needed on cnt_a/cnt_b.
  - SAMPLE (1 cycle): bit = (cnt_a > cnt_b) unsigned; response[i] = bit. If cnt_a == cnt_b, then bit=0 and tie_cnt increments. If i == RESP_BITS-1, next state DONE; otherwise i++ and next state CLEAR.
  - DONE (1 cycle): resp_valid=1. Next state IDLE.
- Select wrap: addition is modulo 2^SEL_W (base 15, i=0 gives sel_a=15, sel_b=0).
- Counter wrap inside the window is not detected; the raw CNT_W values are compared.
- Cycles per pair = WINDOW_CYCLES + SETTLE_CYCLES + 2. resp_valid asserts RESP_BITS*(W+S+2)+1 cycles after the cycle in which start is accepted.
- start while busy is ignored; challenge changes while busy are ignored.
- sel_a/sel_b hold their last values through DONE/IDLE; osc_en is 0 in IDLE and DONE.
- Reset mid-run aborts immediately: osc_en drops, response and tie_cnt are cleared, no resp_valid.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE), default parameter constants, tie_cnt width function.
- One sub-module, puf_window_timer: loadable down-counter with a zero flag, shared by RUN and SETTLE.

Test Plan:
- Reset with W=16, S=4, RESP_BITS=8, then start with challenge=0 and cnt_a=200, cnt_b=100 constant -> response=8'hFF, tie_cnt=0, resp_valid pulse 177 cycles after start accepted.
- Same run with cnt_a=5, cnt_b=5 -> response=8'h00, tie_cnt=8.
- challenge=14 -> sel_a/sel_b sequence (14,15),(0,1),(2,3)…(12,13). Each CLEAR has cnt_clr high for exactly 1 cycle, and osc_en is high for exactly 16 cycles per pair.
- Model counts where pair i has cnt_a>cnt_b only for odd i -> response=8'hAA.
- start pulsed again at cycle 50 of a run with a different challenge -> ignored; selects and response follow the original run.
- rst_n asserted at cycle 90 -> same cycle osc_en=0, busy=0, response=0. A subsequent start runs a full 177-cycle sequence.
